// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline hazard control (redirect flush, load-use stall, LM/SM sequencing)
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] id_ir,
  input  logic        id_rA_used,
  input  logic        id_rB_used,
  input  logic        ex_load,
  input  logic        ex_wr_en,
  input  logic [2:0]  ex_wr_addr,
  input  logic        branch_taken,
  input  logic        r7_wb,
  output logic        stall_pc,
  output logic        hold_ifid,
  output logic        flush_ifid,
  output logic        flush_idrr,
  output logic        flush_rrex,
  output logic        first_multiple,
  output logic        mult_active,
  output logic        mult_last,
  output logic [2:0]  mult_reg
);

  localparam logic [3:0] c_OP_LM = 4'b0110;
  localparam logic [3:0] c_OP_SM = 4'b0111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_mask, w_mask_nxt;
  logic        r_first_pending, w_first_pending_nxt;

  logic        w_redirect;
  logic        w_load_use;
  logic        w_is_mult_op;
  logic [7:0]  w_src_mask;
  logic [7:0]  w_low_bit;
  logic [7:0]  w_rest_mask;
  logic [2:0]  w_low_idx;

  assign w_redirect   = branch_taken | r7_wb;
  assign w_load_use   = ex_load & ex_wr_en &
                        ((id_rA_used & (ex_wr_addr == id_ir[11:9])) |
                         (id_rB_used & (ex_wr_addr == id_ir[8:6])));
  assign w_is_mult_op = (id_ir[15:12] == c_OP_LM) | (id_ir[15:12] == c_OP_SM);

  // In MULT the instruction word is ignored; the remaining mask drives sequencing.
  assign w_src_mask  = (r_state == ST_MULT) ? r_mask : id_ir[7:0];
  assign w_low_bit   = w_src_mask & (~w_src_mask + 8'd1);
  assign w_rest_mask = w_src_mask & ~w_low_bit;

  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_low_bit[i]) w_low_idx = i[2:0];
    end
  end

  always_comb begin
    stall_pc            = 1'b0;
    hold_ifid           = 1'b0;
    flush_ifid          = 1'b0;
    flush_idrr          = 1'b0;
    flush_rrex          = 1'b0;
    first_multiple      = 1'b0;
    mult_active         = 1'b0;
    mult_last           = 1'b0;
    mult_reg            = 3'd0;
    w_state_nxt         = r_state;
    w_mask_nxt          = r_mask;
    w_first_pending_nxt = r_first_pending;

    // Outputs are gated by reset so they drop immediately, not at the next edge.
    if (!reset) begin
      w_state_nxt         = ST_IDLE;
      w_mask_nxt          = 8'd0;
      w_first_pending_nxt = 1'b0;
    end else if (w_redirect) begin
      flush_ifid          = 1'b1;
      flush_idrr          = 1'b1;
      flush_rrex          = 1'b1;
      w_state_nxt         = ST_IDLE;
      w_mask_nxt          = 8'd0;
      w_first_pending_nxt = 1'b0;
    end else if (w_load_use) begin
      stall_pc   = 1'b1;
      hold_ifid  = 1'b1;
      flush_idrr = 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_is_mult_op && (w_src_mask != 8'd0)) begin
        mult_active    = 1'b1;
        first_multiple = 1'b1;
        mult_reg       = w_low_idx;
        if (w_rest_mask == 8'd0) begin
          mult_last = 1'b1;
        end else begin
          stall_pc            = 1'b1;
          hold_ifid           = 1'b1;
          w_state_nxt         = ST_MULT;
          w_mask_nxt          = w_rest_mask;
          w_first_pending_nxt = 1'b0;
        end
      end
    end else begin
      mult_active    = 1'b1;
      first_multiple = r_first_pending;
      mult_reg       = w_low_idx;
      w_mask_nxt     = w_rest_mask;
      if (w_rest_mask == 8'd0) begin
        mult_last           = 1'b1;
        w_state_nxt         = ST_IDLE;
        w_first_pending_nxt = 1'b0;
      end else begin
        stall_pc  = 1'b1;
        hold_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_mask          <= 8'd0;
      r_first_pending <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_mask          <= w_mask_nxt;
      r_first_pending <= w_first_pending_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios then randomized traffic against a list-based model.
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] id_ir;
  logic        id_rA_used, id_rB_used, ex_load, ex_wr_en;
  logic [2:0]  ex_wr_addr;
  logic        branch_taken, r7_wb;
  logic        stall_pc, hold_ifid, flush_ifid, flush_idrr, flush_rrex;
  logic        first_multiple, mult_active, mult_last;
  logic [2:0]  mult_reg;

  int checks = 0;
  int errors = 0;

  // Model: list of register indices still to be transferred (empty = no sequence in flight).
  int          q[$];
  int          nq[$];
  logic [10:0] exp_v;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_ir(id_ir),
    .id_rA_used(id_rA_used), .id_rB_used(id_rB_used),
    .ex_load(ex_load), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .branch_taken(branch_taken), .r7_wb(r7_wb),
    .stall_pc(stall_pc), .hold_ifid(hold_ifid), .flush_ifid(flush_ifid),
    .flush_idrr(flush_idrr), .flush_rrex(flush_rrex),
    .first_multiple(first_multiple), .mult_active(mult_active),
    .mult_last(mult_last), .mult_reg(mult_reg)
  );

  always #5 clk = ~clk;

  wire [10:0] obs_v = {stall_pc, hold_ifid, flush_ifid, flush_idrr, flush_rrex,
                       first_multiple, mult_active, mult_last, mult_reg};

  task automatic model_eval();
    logic st, hd, fi, fd, fr, fm, ma, ml;
    logic [2:0] mr;
    int regs[$];
    logic lu;
    {st, hd, fi, fd, fr, fm, ma, ml} = 8'd0;
    mr = 3'd0;
    nq = q;
    lu = ex_load && ex_wr_en &&
         ((id_rA_used && ex_wr_addr == id_ir[11:9]) || (id_rB_used && ex_wr_addr == id_ir[8:6]));
    if (!reset) begin
      nq = {};
    end else if (branch_taken || r7_wb) begin
      fi = 1; fd = 1; fr = 1;
      nq = {};
    end else if (lu) begin
      st = 1; hd = 1; fd = 1;
    end else if (q.size() == 0) begin
      if ((id_ir[15:12] == 4'd6 || id_ir[15:12] == 4'd7) && id_ir[7:0] != 8'd0) begin
        for (int i = 0; i < 8; i++) if (id_ir[i]) regs.push_back(i);
        mr = 3'(regs.pop_front());
        ma = 1; fm = 1;
        ml = (regs.size() == 0);
        st = !ml; hd = !ml;
        nq = regs;
      end
    end else begin
      mr = 3'(nq.pop_front());
      ma = 1; fm = 0;
      ml = (nq.size() == 0);
      st = !ml; hd = !ml;
    end
    exp_v = {st, hd, fi, fd, fr, fm, ma, ml, mr};
  endtask

  task automatic check(input string tag);
    model_eval();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (stall,hold,fif,fidrr,frrex,first,act,last,reg)",
             tag, obs_v, exp_v);
    end
  endtask

  task automatic do_cycle(input string tag);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    q = nq;
    #1;
  endtask

  task automatic clr_haz();
    id_rA_used = 0; id_rB_used = 0; ex_load = 0; ex_wr_en = 0;
    ex_wr_addr = 3'd0; branch_taken = 0; r7_wb = 0;
  endtask

  initial begin
    reset = 1'b0;
    id_ir = 16'h0000;
    clr_haz();
    #1;
    check("reset_state");
    @(posedge clk); q = {}; #1;
    reset = 1'b1;
    do_cycle("idle_nop");

    // LM mask 0x05
    id_ir = 16'h6005;
    do_cycle("lm05_c0");
    do_cycle("lm05_c1");
    id_ir = 16'h0000;
    do_cycle("lm05_c2");

    // load-use on rB
    id_ir = 16'h1050; id_rB_used = 1; ex_load = 1; ex_wr_en = 1; ex_wr_addr = 3'd1;
    do_cycle("loaduse");
    ex_load = 0;
    do_cycle("loaduse_drop");
    clr_haz();

    // SM full mask
    id_ir = 16'h70FF;
    for (int i = 0; i < 8; i++) do_cycle($sformatf("sm_ff_%0d", i));
    id_ir = 16'h0000;
    do_cycle("sm_ff_after");

    // LM with zero mask passes as ordinary
    id_ir = 16'h6000;
    do_cycle("lm_mask0");

    // branch during third micro-op
    id_ir = 16'h60FF;
    do_cycle("br_c0");
    do_cycle("br_c1");
    branch_taken = 1;
    do_cycle("br_c2_flush");
    branch_taken = 0; id_ir = 16'h0000;
    do_cycle("br_after");

    // load-use in second micro-op cycle
    id_ir = 16'h6081;
    do_cycle("lm81_c0");
    id_rA_used = 1; ex_load = 1; ex_wr_en = 1; ex_wr_addr = 3'd0;
    do_cycle("lm81_stall");
    clr_haz();
    do_cycle("lm81_last");
    id_ir = 16'h0000;
    do_cycle("lm81_after");

    // r7 write-back redirect
    r7_wb = 1;
    do_cycle("r7wb");
    r7_wb = 0;

    // async reset mid-sequence
    id_ir = 16'h60FF;
    do_cycle("rst_c0");
    do_cycle("rst_c1");
    reset = 1'b0;
    #1;
    check("rst_async");
    do_cycle("rst_held");
    reset = 1'b1; id_ir = 16'hF000;
    do_cycle("rst_rel0");
    do_cycle("rst_rel1");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      id_ir = 16'($urandom);
      case ($urandom_range(0, 3))
        0: id_ir[15:12] = 4'd6;
        1: id_ir[15:12] = 4'd7;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) id_ir[7:0] = 8'd1 << $urandom_range(0, 7);
      id_rA_used   = 1'($urandom);
      id_rB_used   = 1'($urandom);
      ex_load      = ($urandom_range(0, 3) == 0);
      ex_wr_en     = 1'($urandom);
      ex_wr_addr   = 3'($urandom);
      branch_taken = ($urandom_range(0, 19) == 0);
      r7_wb        = ($urandom_range(0, 29) == 0);
      reset        = ($urandom_range(0, 59) != 0);
      do_cycle("random");
    end
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
